// File: rtl/shift_reg_serializer_pkg.sv
// Shared types for the parallel-to-serial sequencer: FSM state and element order.
package ser_pkg;

  // Sequencer state: IDLE waits for a word, SHIFT streams one out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Element order of the word in flight; MSB-first drives shift_reg l_shift=1 directly.
  typedef enum logic {
    ORD_LSB_FIRST = 1'b0,
    ORD_MSB_FIRST = 1'b1
  } ser_order_e;

  // True when the order flag selects MSB-element-first streaming.
  function automatic logic order_is_msb(input ser_order_e ord);
    return (ord == ORD_MSB_FIRST);
  endfunction

endpackage

// File: rtl/shift_reg_serializer_if.sv
// Parallel word port and serial element port of the serializer, bundled.
// Signal suffixes are from the serializer's point of view.
interface shift_reg_serializer_if #(
  parameter int ELEM_WIDTH = 4,
  parameter int DEPTH      = 8
) ();

  logic [DEPTH-1:0][ELEM_WIDTH-1:0] pdata_i;
  logic                             pvalid_i;
  logic                             pready_o;
  logic                             msb_first_i;
  logic [ELEM_WIDTH-1:0]            sdata_o;
  logic                             svalid_o;
  logic                             sready_i;
  logic                             slast_o;

  // Serializer side: consumes words, produces elements.
  modport slave (
    input  pdata_i, pvalid_i, msb_first_i, sready_i,
    output pready_o, sdata_o, svalid_o, slast_o
  );

  // Environment side: word producer plus element consumer.
  modport master (
    output pdata_i, pvalid_i, msb_first_i, sready_i,
    input  pready_o, sdata_o, svalid_o, slast_o
  );

endinterface

// File: rtl/shift_reg_serializer_shift_reg.sv
// Element-wide shift register: parallel load, shift toward either end, serial out.
// l_shift=1 moves elements toward index DEPTH-1 and presents po[DEPTH-1];
// l_shift=0 moves them toward index 0 and presents po[0].
module shift_reg #(
  parameter int ELEM_WIDTH = 4,
  parameter int DEPTH      = 8
) (
  input  logic                             clk_i,
  input  logic                             arst_n,
  input  logic                             en_i,
  input  logic                             load_i,
  input  logic                             l_shift_i,
  input  logic [ELEM_WIDTH-1:0]            si_i,
  input  logic [DEPTH-1:0][ELEM_WIDTH-1:0] pi_i,
  output logic [ELEM_WIDTH-1:0]            so_o
);

  logic [DEPTH-1:0][ELEM_WIDTH-1:0] po_q;
  logic [DEPTH-1:0][ELEM_WIDTH-1:0] po_d;

  // Next contents: load wins over shift; nothing moves without en_i.
  always_comb begin
    po_d = po_q;
    if (en_i) begin
      if (load_i) begin
        po_d = pi_i;
      end else if (l_shift_i) begin
        po_d = {po_q[DEPTH-2:0], si_i};
      end else begin
        po_d = {si_i, po_q[DEPTH-1:1]};
      end
    end else begin
      po_d = po_q;
    end
  end

  // Storage register, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      po_q <= '0;
    end else begin
      po_q <= po_d;
    end
  end

  assign so_o = l_shift_i ? po_q[DEPTH-1] : po_q[0];

endmodule

// File: rtl/shift_reg_serializer.sv
// Parallel-to-serial sequencer: accepts DEPTH-element words and streams them out one
// element per handshake, LSB- or MSB-element first per word. Holds the FSM, element
// counter, order flag and handshake logic; the data lives in one shift_reg.
// pready_o depends combinationally on sready_i so a new word can load in the same
// cycle the last element leaves, giving gap-free back-to-back words.
module shift_reg_serializer
  import ser_pkg::*;
#(
  parameter  int ELEM_WIDTH = 4,
  parameter  int DEPTH      = 8,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      arst_n,
  input  logic                      clear_i,
  shift_reg_serializer_if.slave     bus,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          count_o
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ser_state_e       state_q, state_d;
  ser_order_e       order_q, order_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic                  svalid;
  logic                  slast;
  logic                  s_hs;
  logic                  p_hs;
  logic                  pready;
  logic                  sr_load;
  logic                  sr_en;
  logic [ELEM_WIDTH-1:0] sr_so;

  assign svalid = (state_q == ST_SHIFT);
  assign slast  = svalid & (count_q == CNT_ONE);
  assign s_hs   = svalid & bus.sready_i;
  assign pready = ((state_q == ST_IDLE) | (s_hs & slast)) & ~clear_i;
  assign p_hs   = bus.pvalid_i & pready;

  // Next state, count, order flag and shift_reg controls; clear_i overrides every handshake.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    order_d = order_q;
    sr_load = 1'b0;
    sr_en   = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (p_hs) begin
            state_d = ST_SHIFT;
            count_d = CNT_FULL;
            order_d = ser_order_e'(bus.msb_first_i);
            sr_load = 1'b1;
            sr_en   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (s_hs) begin
            if (count_q > CNT_ONE) begin
              sr_en   = 1'b1;
              count_d = count_q - CNT_ONE;
            end else if (p_hs) begin
              count_d = CNT_FULL;
              order_d = ser_order_e'(bus.msb_first_i);
              sr_load = 1'b1;
              sr_en   = 1'b1;
            end else begin
              state_d = ST_IDLE;
              count_d = '0;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State, count and order registers; reset drops any word in flight.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      order_q <= ORD_LSB_FIRST;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      order_q <= order_d;
    end
  end

  shift_reg #(
    .ELEM_WIDTH (ELEM_WIDTH),
    .DEPTH      (DEPTH)
  ) u_shift_reg (
    .clk_i     (clk_i),
    .arst_n    (arst_n),
    .en_i      (sr_en),
    .load_i    (sr_load),
    .l_shift_i (order_is_msb(order_q)),
    .si_i      ({ELEM_WIDTH{1'b0}}),
    .pi_i      (bus.pdata_i),
    .so_o      (sr_so)
  );

  assign bus.pready_o = pready;
  assign bus.svalid_o = svalid;
  assign bus.slast_o  = slast;
  assign bus.sdata_o  = svalid ? sr_so : {ELEM_WIDTH{1'b0}};
  assign busy_o       = svalid;
  assign count_o      = count_q;

endmodule

// File: tb/tb_shift_reg_serializer.sv
// Self-checking bench for shift_reg_serializer. The reference model is a queue of the
// elements still owed for the accepted word(s): outputs are derived from its head and
// length, handshakes pop it, accepted words push their elements in the chosen order.
module tb_shift_reg_serializer;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       clear;
  logic       clear2;
  logic       busy;
  logic       busy2;
  logic [3:0] count;
  logic [1:0] count2;

  int n_total = 0;
  int n_bad   = 0;
  int n_shs   = 0;
  int n_shs2  = 0;

  logic [3:0]  q8[$];
  logic [3:0]  q2[$];
  logic [32:0] tx8[$];
  logic [8:0]  tx2[$];
  bit          acc8;
  bit          acc2;

  shift_reg_serializer_if #(.ELEM_WIDTH(4), .DEPTH(8)) bus ();
  shift_reg_serializer_if #(.ELEM_WIDTH(4), .DEPTH(2)) bus2 ();

  shift_reg_serializer #(.ELEM_WIDTH(4), .DEPTH(8)) dut (
    .clk_i(clk), .arst_n(arst_n), .clear_i(clear), .bus(bus), .busy_o(busy), .count_o(count)
  );

  shift_reg_serializer #(.ELEM_WIDTH(4), .DEPTH(2)) dut2 (
    .clk_i(clk), .arst_n(arst_n), .clear_i(clear2), .bus(bus2), .busy_o(busy2), .count_o(count2)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the DEPTH=8 instance: drive, compare against the model, advance the model.
  task automatic cycle8(input logic pv, input logic msb, input logic [31:0] w,
                        input logic sr, input logic clr);
    logic       exp_sv, exp_sl, exp_pr;
    logic [3:0] exp_sd;
    @(negedge clk);
    bus.pvalid_i = pv; bus.msb_first_i = msb; bus.pdata_i = w; bus.sready_i = sr; clear = clr;
    #1;
    exp_sv = (q8.size() != 0);
    exp_sd = exp_sv ? q8[0] : 4'h0;
    exp_sl = (q8.size() == 1);
    exp_pr = (!exp_sv || (sr && exp_sl)) && !clr;
    check_val("svalid", bus.svalid_o, exp_sv);
    check_val("sdata",  bus.sdata_o,  exp_sd);
    check_val("slast",  bus.slast_o,  exp_sl);
    check_val("pready", bus.pready_o, exp_pr);
    check_val("busy",   busy,         exp_sv);
    check_val("count",  count,        q8.size());
    acc8 = 1'b0;
    if (!arst_n || clr) begin
      q8.delete();
    end else begin
      if (exp_sv && sr) begin
        void'(q8.pop_front());
        n_shs++;
      end
      if (pv && exp_pr) begin
        acc8 = 1'b1;
        for (int i = 0; i < 8; i++) q8.push_back(msb ? w[4*(7-i) +: 4] : w[4*i +: 4]);
      end
    end
  endtask

  // One clock of the DEPTH=2 instance.
  task automatic cycle2(input logic pv, input logic msb, input logic [7:0] w, input logic sr);
    logic       exp_sv, exp_sl, exp_pr;
    logic [3:0] exp_sd;
    @(negedge clk);
    bus2.pvalid_i = pv; bus2.msb_first_i = msb; bus2.pdata_i = w; bus2.sready_i = sr;
    #1;
    exp_sv = (q2.size() != 0);
    exp_sd = exp_sv ? q2[0] : 4'h0;
    exp_sl = (q2.size() == 1);
    exp_pr = !exp_sv || (sr && exp_sl);
    check_val("d2_svalid", bus2.svalid_o, exp_sv);
    check_val("d2_sdata",  bus2.sdata_o,  exp_sd);
    check_val("d2_slast",  bus2.slast_o,  exp_sl);
    check_val("d2_pready", bus2.pready_o, exp_pr);
    check_val("d2_count",  count2,        q2.size());
    acc2 = 1'b0;
    if (exp_sv && sr) begin
      void'(q2.pop_front());
      n_shs2++;
    end
    if (pv && exp_pr) begin
      acc2 = 1'b1;
      for (int i = 0; i < 2; i++) q2.push_back(msb ? w[4*(1-i) +: 4] : w[4*i +: 4]);
    end
  endtask

  // Feed queued words to the DEPTH=8 instance for a fixed number of cycles.
  task automatic run8(input int ncyc, input int rdy_pct);
    for (int c = 0; c < ncyc; c++) begin
      logic        pv;
      logic [32:0] h;
      pv = (tx8.size() != 0);
      h  = pv ? tx8[0] : 33'h0;
      cycle8(pv, h[32], h[31:0], ($urandom_range(99, 0) < rdy_pct), 1'b0);
      if (acc8) void'(tx8.pop_front());
    end
  endtask

  // Feed queued words to the DEPTH=2 instance for a fixed number of cycles.
  task automatic run2(input int ncyc, input int rdy_pct);
    for (int c = 0; c < ncyc; c++) begin
      logic       pv;
      logic [8:0] h;
      pv = (tx2.size() != 0);
      h  = pv ? tx2[0] : 9'h0;
      cycle2(pv, h[8], h[7:0], ($urandom_range(99, 0) < rdy_pct));
      if (acc2) void'(tx2.pop_front());
    end
  endtask

  initial begin
    int base;
    arst_n = 1'b0;
    clear  = 1'b0;
    clear2 = 1'b0;
    bus.pvalid_i = 1'b1; bus.msb_first_i = 1'b0; bus.pdata_i = 32'h0; bus.sready_i = 1'b0;
    bus2.pvalid_i = 1'b0; bus2.msb_first_i = 1'b0; bus2.pdata_i = 8'h0; bus2.sready_i = 1'b0;

    // Reset held with a word offered: nothing accepted, idle outputs.
    for (int i = 0; i < 3; i++) cycle8(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
    bus.pvalid_i = 1'b0;
    arst_n = 1'b1;
    cycle8(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Element order, LSB-first then MSB-first.
    tx8.push_back({1'b0, 32'h76543210});
    run8(10, 100);
    tx8.push_back({1'b1, 32'h76543210});
    run8(10, 100);
    check_val("order_drain", q8.size() + tx8.size(), 0);

    // Back-to-back words with no bubble.
    tx8.push_back({1'b0, 32'h76543210});
    tx8.push_back({1'b0, 32'hFEDCBA98});
    n_shs = 0;
    run8(17, 100);
    check_val("b2b_elems", n_shs, 16);
    check_val("b2b_drain", q8.size() + tx8.size(), 0);

    // Random backpressure over 20 random words.
    for (int i = 0; i < 20; i++) tx8.push_back({1'($urandom_range(1, 0)), 32'($urandom)});
    run8(700, 50);
    check_val("bp_drain", q8.size() + tx8.size(), 0);

    // Flush after three elements, then a full MSB-first word.
    tx8.push_back({1'b0, 32'h76543210});
    run8(4, 100);
    check_val("flush_pre", q8.size(), 5);
    cycle8(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle8(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tx8.push_back({1'b1, 32'h89ABCDEF});
    base = n_shs;
    run8(12, 100);
    check_val("flush_next", n_shs - base, 8);

    // Asynchronous reset in the middle of a word.
    tx8.push_back({1'b0, 32'h76543210});
    run8(6, 100);
    #2;
    arst_n = 1'b0;
    #1;
    check_val("arst_svalid", bus.svalid_o, 1'b0);
    check_val("arst_slast",  bus.slast_o,  1'b0);
    check_val("arst_busy",   busy,         1'b0);
    check_val("arst_count",  count,        4'd0);
    check_val("arst_sdata",  bus.sdata_o,  4'h0);
    check_val("arst_pready", bus.pready_o, 1'b1);
    q8.delete();
    cycle8(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle8(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    arst_n = 1'b1;
    tx8.push_back({1'b0, 32'h13579BDF});
    run8(11, 100);
    check_val("arst_resume", q8.size() + tx8.size(), 0);

    // DEPTH=2 instance: back-to-back then random backpressure.
    for (int i = 0; i < 10; i++) tx2.push_back({1'($urandom_range(1, 0)), 8'($urandom)});
    run2(21, 100);
    check_val("d2_elems", n_shs2, 20);
    for (int i = 0; i < 10; i++) tx2.push_back({1'($urandom_range(1, 0)), 8'($urandom)});
    run2(120, 50);
    check_val("d2_drain", q2.size() + tx2.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
